// File: rtl/memory_game_pkg.sv
// Shared definitions for the Memory Game: card state codes, controller FSM encoding, default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memory_game_pkg;

  localparam int DEF_N_CARDS = 16;
  localparam int DEF_IDX_W   = 4;
  localparam int DEF_COLOR_W = 4;

  // Per-card display state, two bits per card in the packed board vector.
  typedef enum logic [1:0] {
    CARD_HIDDEN   = 2'b00,
    CARD_REVEALED = 2'b01,
    CARD_MATCHED  = 2'b10
  } card_state_e;

  // Round sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_READ_FIRST,
    ST_WAIT_SECOND,
    ST_READ_SECOND,
    ST_COMPARE,
    ST_SHOW,
    ST_RESOLVE,
    ST_DONE
  } ctrl_state_e;

  // Clicks are only accepted while waiting for the first or second card of a pair.
  function automatic logic is_wait_state(ctrl_state_e s);
    return (s == ST_WAIT_FIRST) || (s == ST_WAIT_SECOND);
  endfunction

endpackage

// File: rtl/pair_match_controller_show_timer.sv
// Loadable down-counter with a done flag; holds a mismatched pair on screen for a fixed time.
// Latency: load takes effect next cycle; done is high while the count is zero.
// Backpressure: none; counts only while enabled and stops at zero.
module show_timer #(
  parameter int unsigned TICKS = 65_000_000,
  parameter int          TW    = (TICKS > 1) ? $clog2(TICKS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  logic [TW-1:0] cnt_q;

  // Clear wins over load, load wins over counting; the counter never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= TW'(TICKS - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pair_match_controller.sv
// Sequences one Memory Game round: reveals clicked cards, compares pair colours, shows/hides or retires pairs, flags game over.
// Latency: click to reveal 1 cycle; second click to match 3 cycles; mismatch to hide 3 + SHOW_TICKS cycles.
// Backpressure: busy high outside the two wait states; clicks arriving then are dropped, never queued.
module pair_match_controller
  import memory_game_pkg::*;
#(
  parameter int N_CARDS    = DEF_N_CARDS,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int SHOW_TICKS = 65_000_000,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_start,
  input  logic                 card_click,
  input  logic [IDX_W-1:0]     card_idx,
  output logic [IDX_W-1:0]     color_rd_idx,
  input  logic [COLOR_W-1:0]   color_rd_data,
  output logic [2*N_CARDS-1:0] card_state,
  output logic                 update_req,
  output logic [IDX_W-1:0]     pairs_found,
  output logic [CNT_W-1:0]     moves,
  output logic                 busy,
  output logic                 game_over
);

  localparam logic [IDX_W:0]   N_CARDS_L = (IDX_W+1)'(N_CARDS);
  localparam logic [IDX_W-1:0] ALL_PAIRS = IDX_W'(N_CARDS / 2);

  ctrl_state_e          state_q, state_d;
  logic [2*N_CARDS-1:0] card_q, card_d;
  logic [IDX_W-1:0]     first_idx_q, first_idx_d;
  logic [IDX_W-1:0]     second_idx_q, second_idx_d;
  logic [COLOR_W-1:0]   first_color_q, first_color_d;
  logic [COLOR_W-1:0]   second_color_q, second_color_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic                 upd_q, upd_d;
  logic [IDX_W-1:0]     pairs_q, pairs_d;
  logic [CNT_W-1:0]     moves_q, moves_d;
  logic                 busy_q, busy_d;
  logic                 game_over_q, game_over_d;

  logic [1:0]           sel_state;
  logic                 click_hidden;
  logic                 tmr_clr, tmr_load, tmr_en, tmr_done;

  show_timer #(
    .TICKS (SHOW_TICKS)
  ) u_show_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

  // Look up the state of the clicked card; out-of-range indices read as non-hidden so they are never accepted.
  always_comb begin
    sel_state = CARD_MATCHED;
    for (int i = 0; i < N_CARDS; i++) begin
      if (card_idx == IDX_W'(i)) begin
        sel_state = card_q[2*i +: 2];
      end
    end
    click_hidden = card_click && ({1'b0, card_idx} < N_CARDS_L) && (sel_state == CARD_HIDDEN);
  end

  // Round sequencer: next state, board updates, counters and registered output values.
  always_comb begin
    state_d        = state_q;
    card_d         = card_q;
    first_idx_d    = first_idx_q;
    second_idx_d   = second_idx_q;
    first_color_d  = first_color_q;
    second_color_d = second_color_q;
    rd_idx_d       = rd_idx_q;
    upd_d          = 1'b0;
    pairs_d        = pairs_q;
    moves_d        = moves_q;
    tmr_clr        = 1'b0;
    tmr_load       = 1'b0;
    tmr_en         = 1'b0;

    if (game_start) begin
      // A restart beats any click in the same cycle, from every state.
      card_d  = '0;
      pairs_d = '0;
      moves_d = '0;
      upd_d   = 1'b1;
      tmr_clr = 1'b1;
      state_d = ST_WAIT_FIRST;
    end else begin
      case (state_q)
        ST_WAIT_FIRST: begin
          if (click_hidden) begin
            first_idx_d = card_idx;
            rd_idx_d    = card_idx;
            for (int i = 0; i < N_CARDS; i++) begin
              if (card_idx == IDX_W'(i)) card_d[2*i +: 2] = CARD_REVEALED;
            end
            upd_d   = 1'b1;
            state_d = ST_READ_FIRST;
          end
        end
        ST_READ_FIRST: begin
          first_color_d = color_rd_data;
          state_d       = ST_WAIT_SECOND;
        end
        ST_WAIT_SECOND: begin
          if (click_hidden && (card_idx != first_idx_q)) begin
            second_idx_d = card_idx;
            rd_idx_d     = card_idx;
            for (int i = 0; i < N_CARDS; i++) begin
              if (card_idx == IDX_W'(i)) card_d[2*i +: 2] = CARD_REVEALED;
            end
            upd_d   = 1'b1;
            state_d = ST_READ_SECOND;
          end
        end
        ST_READ_SECOND: begin
          second_color_d = color_rd_data;
          state_d        = ST_COMPARE;
        end
        ST_COMPARE: begin
          if (moves_q != '1) moves_d = moves_q + CNT_W'(1);
          if (first_color_q == second_color_q) begin
            for (int i = 0; i < N_CARDS; i++) begin
              if ((first_idx_q == IDX_W'(i)) || (second_idx_q == IDX_W'(i))) begin
                card_d[2*i +: 2] = CARD_MATCHED;
              end
            end
            pairs_d = pairs_q + IDX_W'(1);
            upd_d   = 1'b1;
            state_d = ST_RESOLVE;
          end else begin
            tmr_load = 1'b1;
            state_d  = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (tmr_done) begin
            for (int i = 0; i < N_CARDS; i++) begin
              if ((first_idx_q == IDX_W'(i)) || (second_idx_q == IDX_W'(i))) begin
                card_d[2*i +: 2] = CARD_HIDDEN;
              end
            end
            upd_d   = 1'b1;
            state_d = ST_RESOLVE;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_RESOLVE: begin
          state_d = (pairs_q == ALL_PAIRS) ? ST_DONE : ST_WAIT_FIRST;
        end
        default: begin
          // IDLE and DONE hold until game_start.
          state_d = state_q;
        end
      endcase
    end

    busy_d      = !is_wait_state(state_d);
    game_over_d = (state_d == ST_DONE);
  end

  // State and output registers; synchronous reset returns everything to the power-up values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      card_q         <= '0;
      first_idx_q    <= '0;
      second_idx_q   <= '0;
      first_color_q  <= '0;
      second_color_q <= '0;
      rd_idx_q       <= '0;
      upd_q          <= 1'b0;
      pairs_q        <= '0;
      moves_q        <= '0;
      busy_q         <= 1'b1;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      card_q         <= card_d;
      first_idx_q    <= first_idx_d;
      second_idx_q   <= second_idx_d;
      first_color_q  <= first_color_d;
      second_color_q <= second_color_d;
      rd_idx_q       <= rd_idx_d;
      upd_q          <= upd_d;
      pairs_q        <= pairs_d;
      moves_q        <= moves_d;
      busy_q         <= busy_d;
      game_over_q    <= game_over_d;
    end
  end

  assign color_rd_idx = rd_idx_q;
  assign card_state   = card_q;
  assign update_req   = upd_q;
  assign pairs_found  = pairs_q;
  assign moves        = moves_q;
  assign busy         = busy_q;
  assign game_over    = game_over_q;

endmodule
